fifo_wr_arbiter: RTL and testbench

Round-robin, packet-atomic write arbiter that shares one block-RAM FIFO write port between N_ requesters. A granted requester keeps the FIFO until it delivers its last word, so packets from different requesters never interleave. A watchdog releases a stalled grant. The block sits between the producer blocks and the FIFO's we/din/fillc interface. The FIFO read side is not touched.

---
 rtl/fifoarb_pkg.sv | 20 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 43 ++++
 rtl/fifo_wr_arbiter.sv | 125 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifoarb_pkg.sv
// -----------------------------------------------------------------------------
// fifoarb_pkg
// Shared types and helpers for the FIFO write arbiter and its round-robin
// picker.
//   arb_state_t : arbiter FSM states (IDLE, LOCKED)
//   idx_w(n)    : width of an index that can address n items, never below 1
// -----------------------------------------------------------------------------
package fifoarb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // $clog2 returns 0 for n <= 1, which would create a zero-width vector.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. It scans req cyclically, starting just
// after prev, and returns the first set bit. prev itself is considered last,
// so it can only win again when nobody else is requesting.
//   req   : request vector, one bit per requester
//   prev  : index of the previous winner (must be < N_)
//   idx   : winning index (equals prev when nothing is requested)
//   valid : at least one request bit is set
// -----------------------------------------------------------------------------
module rr_pick
  import fifoarb_pkg::*;
#(
  parameter  int N_ = 4,
  localparam int IW = idx_w(N_)
) (
  input  logic [N_-1:0] req,
  input  logic [IW-1:0] prev,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] cand;

  // NOTE: every output of a combinational block gets a default first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    idx   = prev;
    valid = 1'b0;
    cand  = '0;
    // Walk the offsets from farthest to nearest. The nearest set bit is then
    // the last one assigned, and it wins. The wrap is modulo N_, so this also
    // works when N_ is not a power of two.
    for (int k = N_; k >= 1; k--) begin
      cand = IW'((int'(prev) + k) % N_);
      if (req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Packet-atomic round-robin arbiter for one FIFO write port. A granted
// requester keeps the port until its last word transfers, so packets from
// different requesters never interleave. A watchdog releases a grant whose
// holder goes quiet mid-packet. FIFO backpressure never counts as idle time.
//   clk, rst_  : clock; synchronous active-low reset
//   req_v      : per-requester word valid
//   req_last   : per-requester last-word flag, qualified by req_v
//   req_data   : requester i's word is at [i*DATA_ +: DATA_]
//   req_rdy    : per-requester accept (combinational)
//   fifo_we    : FIFO write enable (combinational)
//   fifo_din   : FIFO write data (the grant holder's word)
//   fifo_fillc : FIFO fill count
//   gnt_id     : current or most recent grant holder
//   busy       : high while a packet is locked
//   err        : one-cycle pulse when the watchdog aborts a packet
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifoarb_pkg::*;
#(
  parameter  int N_       = 4,
  parameter  int DATA_    = 8,
  parameter  int ADDR_    = 8,
  parameter  int TIMEOUT_ = 16,
  localparam int IW       = idx_w(N_)
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic [N_-1:0]       req_v,
  input  logic [N_-1:0]       req_last,
  input  logic [N_*DATA_-1:0] req_data,
  output logic [N_-1:0]       req_rdy,
  output logic                fifo_we,
  output logic [DATA_-1:0]    fifo_din,
  input  logic [ADDR_:0]      fifo_fillc,
  output logic [IW-1:0]       gnt_id,
  output logic                busy,
  output logic                err
);

  localparam int              CW       = idx_w(TIMEOUT_ + 1);
  localparam bit              WD_EN    = (TIMEOUT_ != 0);
  localparam logic [CW-1:0]   WD_MAX   = CW'((TIMEOUT_ == 0) ? 0 : TIMEOUT_ - 1);
  localparam logic [ADDR_:0]  FULL_LVL = {1'b1, {ADDR_{1'b0}}};

  arb_state_t    state;
  logic [CW-1:0] wd_cnt;
  logic          full;
  logic          last_g;
  logic [IW-1:0] pick_idx;
  logic          pick_v;

  assign full   = (fifo_fillc == FULL_LVL);
  assign last_g = req_last[gnt_id];

  rr_pick #(.N_(N_)) u_pick (
    .req   (req_v),
    .prev  (gnt_id),
    .idx   (pick_idx),
    .valid (pick_v)
  );

  // The handshake is combinational, so a word can move on every LOCKED cycle.
  // It is gated with rst_ because the reset is synchronous: without the gate,
  // the word in flight would still be written on the reset edge itself.
  always_comb begin
    req_rdy  = '0;
    fifo_we  = 1'b0;
    fifo_din = '0;
    if (state == LOCKED) begin
      fifo_din = req_data[gnt_id*DATA_ +: DATA_];
      if (rst_) begin
        req_rdy[gnt_id] = !full;
        fifo_we         = req_v[gnt_id] && !full;
      end
    end
  end

  // NOTE: sequential state is assigned with <= only. Blocking assignments
  // here would make the result depend on the order in which processes run.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state  <= IDLE;
      gnt_id <= IW'(N_ - 1);
      wd_cnt <= '0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_v) begin
            gnt_id <= pick_idx;
            state  <= LOCKED;
            busy   <= 1'b1;
            wd_cnt <= '0;
          end
        end
        LOCKED: begin
          if (fifo_we) begin
            wd_cnt <= '0;
            if (last_g) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (!full && WD_EN) begin
            // Only a quiet holder with FIFO space counts as idle time. A full
            // FIFO holds the counter.
            if (wd_cnt == WD_MAX) begin
              state  <= IDLE;
              busy   <= 1'b0;
              err    <= 1'b1;
              wd_cnt <= '0;
            end else begin
              wd_cnt <= wd_cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed bench for fifo_wr_arbiter with N_=4, ADDR_=3 (depth 8) and
// TIMEOUT_=4. Per-requester packet sources and a FIFO model surround the DUT.
// Every word expected to reach the FIFO is pushed to a scoreboard queue when
// its packet is queued. The queue is popped whenever the DUT asserts fifo_we.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst_ = 1'b0;
  logic [N-1:0]    req_v = '0;
  logic [N-1:0]    req_last = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_rdy;
  logic            fifo_we;
  logic [DW-1:0]   fifo_din;
  logic [AW:0]     fifo_fillc = '0;
  logic [1:0]      gnt_id;
  logic            busy;
  logic            err;

  fifo_wr_arbiter #(.N_(N), .DATA_(DW), .ADDR_(AW), .TIMEOUT_(TO)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .req_v      (req_v),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_rdy    (req_rdy),
    .fifo_we    (fifo_we),
    .fifo_din   (fifo_din),
    .fifo_fillc (fifo_fillc),
    .gnt_id     (gnt_id),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            err_cnt = 0;
  int            e0;
  logic [8:0]    src_q [N][$];   // {last, data} per requester
  logic [DW-1:0] exp_q [$];      // scoreboard: words expected at the FIFO
  logic [DW-1:0] fifo_q [$];     // FIFO contents model
  logic          rst_next = 1'b0;
  logic          rd = 1'b0;
  logic [N-1:0]  taken;
  logic          we_s;
  logic [DW-1:0] din_s;
  logic [N-1:0]  s_rdy;
  logic          s_we, s_busy, s_err;
  logic [1:0]    s_gnt;
  logic [AW:0]   s_fill;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_heads();
    logic [8:0] h;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        h = src_q[i][0];
        req_v[i]            = 1'b1;
        req_last[i]         = h[8];
        req_data[i*DW +: DW] = h[DW-1:0];
      end else begin
        req_v[i]            = 1'b0;
        req_last[i]         = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  // Queue n words base, base+1, ... on requester id. The first n_exp words are
  // expected to reach the FIFO.
  task automatic send(input int id, input int n, input logic [7:0] base,
                      input bit with_last, input int n_exp);
    logic [7:0] d;
    for (int k = 0; k < n; k++) begin
      d = base + 8'(k);
      src_q[id].push_back({with_last && (k == n - 1), d});
      if (k < n_exp) exp_q.push_back(d);
    end
    drive_heads();
  endtask

  // One clock cycle. Capture the handshake just before the edge, update the
  // FIFO model and the sources just after it, then sample the outputs at the
  // falling edge into s_*.
  task automatic tick();
    logic [8:0] h;
    int         sz;
    #1;
    we_s  = fifo_we;
    din_s = fifo_din;
    taken = req_v & req_rdy;
    if (we_s) begin
      check("no_write_at_full", 32'(fifo_fillc == 4'd8), 32'd0);
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL sb_extra_write: observed write of %0h, expected no write", din_s);
      end
      if (exp_q.size() > 0) check("sb_data", 32'(din_s), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
    sz = fifo_q.size();
    if (we_s) fifo_q.push_back(din_s);
    if (rd && sz > 0) h = 9'(fifo_q.pop_front());
    fifo_fillc = (AW+1)'(fifo_q.size());
    for (int i = 0; i < N; i++) if (taken[i]) h = src_q[i].pop_front();
    // Producers are reset together with the arbiter, so they abandon their packets.
    if (!rst_) for (int i = 0; i < N; i++) src_q[i].delete();
    rst_ = rst_next;
    drive_heads();
    @(negedge clk);
    s_rdy  = req_rdy;
    s_we   = fifo_we;
    s_busy = busy;
    s_err  = err;
    s_gnt  = gnt_id;
    s_fill = fifo_fillc;
    if (err) err_cnt++;
  endtask

  initial begin
    // ---- Reset state ----
    rst_next = 1'b0;
    repeat (2) tick();
    check("rst_busy", 32'(s_busy), 32'd0);
    check("rst_rdy",  32'(s_rdy),  32'd0);
    check("rst_we",   32'(s_we),   32'd0);
    check("rst_err",  32'(s_err),  32'd0);
    check("rst_gnt",  32'(s_gnt),  32'd3);
    rst_next = 1'b1;
    tick();

    // ---- Interleave guard: requesters 0 and 2 start together ----
    send(0, 3, 8'hA0, 1'b1, 3);
    send(2, 3, 8'hC0, 1'b1, 3);
    for (int t = 0; t < 8; t++) begin
      tick();
      check("il_busy", 32'(s_busy), 32'(t != 3 && t != 7));
      check("il_we",   32'(s_we),   32'(t != 3 && t != 7));
      check("il_gnt",  32'(s_gnt),  (t < 4) ? 32'd0 : 32'd2);
      check("il_rdy",  32'(s_rdy),  (t == 3 || t == 7) ? 32'd0 : ((t < 4) ? 32'd1 : 32'd4));
    end
    rd = 1'b1;
    repeat (8) tick();
    check("il_drained", 32'(s_fill), 32'd0);

    // ---- Reset pulse between tests, then round-robin fairness ----
    rst_next = 1'b0;
    tick();
    check("rst2_busy", 32'(s_busy), 32'd0);
    rst_next = 1'b1;
    tick();
    check("rst2_gnt", 32'(s_gnt), 32'd3);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) send(i, 1, 8'h10 + 8'(r*4 + i), 1'b1, 1);
    for (int t = 0; t < 16; t++) begin
      tick();
      check("rr_we", 32'(s_we), 32'(t % 2 == 0));
      if (t % 2 == 0) check("rr_gnt", 32'(s_gnt), 32'((t / 2) % 4));
    end
    repeat (3) tick();
    check("rr_drained", 32'(s_fill), 32'd0);

    // ---- Full backpressure: 10-word packet from requester 1, no reads ----
    rd = 1'b0;
    send(1, 10, 8'h40, 1'b1, 10);
    for (int t = 0; t < 8; t++) begin
      tick();
      check("bp_we",   32'(s_we),   32'd1);
      check("bp_fill", 32'(s_fill), 32'(t));
    end
    tick();
    check("bp_full_fill", 32'(s_fill), 32'd8);
    check("bp_full_rdy",  32'(s_rdy),  32'd0);
    check("bp_full_we",   32'(s_we),   32'd0);
    e0 = err_cnt;
    repeat (6) begin
      tick();
      check("bp_stall_busy", 32'(s_busy), 32'd1);
    end
    rd = 1'b1;
    tick();
    check("bp_resume_we",   32'(s_we),   32'd1);
    check("bp_resume_fill", 32'(s_fill), 32'd7);
    tick();
    check("bp_last_rdy", 32'(s_rdy), 32'd2);
    tick();
    check("bp_done_busy", 32'(s_busy), 32'd0);
    check("bp_no_err",    32'(err_cnt - e0), 32'd0);
    repeat (8) tick();

    // ---- Watchdog: requester 3 stalls mid-packet, requester 0 waits ----
    send(3, 2, 8'h60, 1'b0, 2);
    tick();
    check("wd_gnt", 32'(s_gnt), 32'd3);
    send(0, 1, 8'h70, 1'b1, 1);
    tick();
    check("wd_word2", 32'(s_we), 32'd1);
    e0 = err_cnt;
    repeat (4) begin
      tick();
      check("wd_wait_err",  32'(s_err),  32'd0);
      check("wd_wait_busy", 32'(s_busy), 32'd1);
    end
    tick();
    check("wd_abort_err",  32'(s_err),  32'd1);
    check("wd_abort_busy", 32'(s_busy), 32'd0);
    check("wd_abort_gnt",  32'(s_gnt),  32'd3);
    tick();
    check("wd_next_err", 32'(s_err), 32'd0);
    check("wd_next_gnt", 32'(s_gnt), 32'd0);
    check("wd_next_rdy", 32'(s_rdy), 32'd1);
    tick();
    check("wd_err_once", 32'(err_cnt - e0), 32'd1);

    // ---- Reset mid-packet ----
    send(0, 3, 8'h80, 1'b1, 1);
    tick();
    check("mr_word1", 32'(s_we), 32'd1);
    rst_next = 1'b0;
    tick();
    check("mr_in_rst_we",  32'(s_we),  32'd0);
    check("mr_in_rst_rdy", 32'(s_rdy), 32'd0);
    rst_next = 1'b1;
    tick();
    check("mr_busy", 32'(s_busy), 32'd0);
    check("mr_rdy",  32'(s_rdy),  32'd0);
    check("mr_gnt",  32'(s_gnt),  32'd3);
    send(0, 1, 8'h90, 1'b1, 1);
    send(1, 1, 8'h91, 1'b1, 1);
    tick();
    check("mr_prio0", 32'(s_gnt), 32'd0);
    tick();
    tick();
    check("mr_then1", 32'(s_gnt), 32'd1);
    tick();

    // ---- Single-word packets from a lone requester 2 ----
    for (int k = 0; k < 6; k++) send(2, 1, 8'hB0 + 8'(k), 1'b1, 1);
    for (int t = 0; t < 12; t++) begin
      tick();
      check("sw_we",  32'(s_we),  32'(t % 2 == 0));
      check("sw_gnt", 32'(s_gnt), 32'd2);
    end

    repeat (3) tick();
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
